// File: rtl/jk_bank_pkg.sv
// Shared encodings for the JK flip-flop bank controller.
package jk_bank_pkg;

  localparam int unsigned N_DEF  = 4;
  localparam int unsigned CW_DEF = 8;
  localparam int unsigned OP_W   = 3;

  localparam logic [OP_W-1:0] OP_NOP    = 3'd0;
  localparam logic [OP_W-1:0] OP_CLEAR  = 3'd1;
  localparam logic [OP_W-1:0] OP_SET    = 3'd2;
  localparam logic [OP_W-1:0] OP_RESET  = 3'd3;
  localparam logic [OP_W-1:0] OP_TOGGLE = 3'd4;
  localparam logic [OP_W-1:0] OP_LOAD   = 3'd5;
  localparam logic [OP_W-1:0] OP_CNT_UP = 3'd6;
  localparam logic [OP_W-1:0] OP_CNT_DN = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_COUNT  = 3'd2,
    S_SETTLE = 3'd3,
    S_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/jk_toggle_vec.sv
// Toggle-enable vector that makes a JK bank step one count up or down.
module jk_toggle_vec #(
  parameter int unsigned N = 4
) (
  input  logic         i_up,
  input  logic [N-1:0] i_q,
  output logic [N-1:0] o_t
);

  logic w_run_up;
  logic w_run_dn;

  // Bit i toggles when every lower bit is 1 (up) or 0 (down).
  always_comb begin
    w_run_up = 1'b1;
    w_run_dn = 1'b1;
    o_t      = '0;
    for (int i = 0; i < int'(N); i++) begin
      o_t[i]   = i_up ? w_run_up : w_run_dn;
      w_run_up = w_run_up & i_q[i];
      w_run_dn = w_run_dn & ~i_q[i];
    end
  end

endmodule

// File: rtl/jk_bank_ctrl.sv
// Command-driven sequencer for an external bank of JK flip-flops.
module jk_bank_ctrl
  import jk_bank_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned CW = CW_DEF
) (
  input  logic            clk,
  input  logic            a_reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [OP_W-1:0] cmd_op,
  input  logic [N-1:0]    cmd_mask,
  input  logic [N-1:0]    cmd_data,
  input  logic [CW-1:0]   cmd_count,
  input  logic [N-1:0]    ff_q,
  output logic [N-1:0]    ff_j,
  output logic [N-1:0]    ff_k,
  output logic            ff_enable,
  output logic            ff_reset,
  output logic            busy,
  output logic            done,
  output logic [N-1:0]    result
);

  state_e          r_state;
  logic [OP_W-1:0] r_op;
  logic [CW-1:0]   r_rem;
  logic [N-1:0]    r_j;
  logic [N-1:0]    r_k;
  logic            r_en;
  logic            r_rst;
  logic            r_busy;
  logic            r_done;
  logic            r_rdy;
  logic [N-1:0]    r_result;

  state_e          w_state_nxt;
  logic [OP_W-1:0] w_op_nxt;
  logic [CW-1:0]   w_rem_nxt;
  logic [N-1:0]    w_j_nxt;
  logic [N-1:0]    w_k_nxt;
  logic            w_en_nxt;
  logic            w_rst_nxt;
  logic            w_is_cnt;
  logic            w_up;
  logic [N-1:0]    w_t;

  assign w_is_cnt = (cmd_op == OP_CNT_UP) || (cmd_op == OP_CNT_DN);
  assign w_up     = (r_op == OP_CNT_UP);

  jk_toggle_vec #(.N(N)) u_tvec (
    .i_up (w_up),
    .i_q  (ff_q),
    .o_t  (w_t)
  );

  // While counting, J/K must track the live Q, so the T vector bypasses the register.
  assign ff_j      = (r_state == S_COUNT) ? w_t : r_j;
  assign ff_k      = (r_state == S_COUNT) ? w_t : r_k;
  assign ff_enable = r_en;
  assign ff_reset  = r_rst;
  assign busy      = r_busy;
  assign done      = r_done;
  assign cmd_ready = r_rdy;
  assign result    = r_result;

  // Next-state decode; bank drive values are computed for the state being entered.
  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_rem_nxt   = r_rem;
    w_j_nxt     = '0;
    w_k_nxt     = '0;
    w_en_nxt    = 1'b0;
    w_rst_nxt   = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid && r_rdy) begin
          w_op_nxt  = cmd_op;
          w_rem_nxt = cmd_count;
          if (w_is_cnt) begin
            if (cmd_count != '0) begin
              w_state_nxt = S_COUNT;
              w_en_nxt    = 1'b1;
            end else begin
              w_state_nxt = S_SETTLE;
            end
          end else begin
            w_state_nxt = S_APPLY;
            w_en_nxt    = (cmd_op != OP_NOP);
            case (cmd_op)
              OP_CLEAR:  w_rst_nxt = 1'b0;
              OP_SET:    w_j_nxt   = cmd_mask;
              OP_RESET:  w_k_nxt   = cmd_mask;
              OP_TOGGLE: begin
                w_j_nxt = cmd_mask;
                w_k_nxt = cmd_mask;
              end
              OP_LOAD: begin
                w_j_nxt = cmd_mask & cmd_data;
                w_k_nxt = cmd_mask & ~cmd_data;
              end
              default: ;
            endcase
          end
        end
      end
      S_APPLY:  w_state_nxt = S_SETTLE;
      S_COUNT: begin
        if (r_rem == CW'(1)) begin
          w_state_nxt = S_SETTLE;
        end else begin
          w_rem_nxt = r_rem - CW'(1);
          w_en_nxt  = 1'b1;
        end
      end
      S_SETTLE: w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // State, command latches and registered outputs.
  always_ff @(posedge clk or negedge a_reset) begin
    if (!a_reset) begin
      r_state  <= S_IDLE;
      r_op     <= OP_NOP;
      r_rem    <= '0;
      r_j      <= '0;
      r_k      <= '0;
      r_en     <= 1'b0;
      r_rst    <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_rdy    <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_rem   <= w_rem_nxt;
      r_j     <= w_j_nxt;
      r_k     <= w_k_nxt;
      r_en    <= w_en_nxt;
      r_rst   <= w_rst_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);
      r_rdy   <= (w_state_nxt == S_IDLE);
      if (r_state == S_SETTLE) begin
        r_result <= ff_q;
      end
    end
  end

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Randomized self-checking bench for jk_bank_ctrl with a behavioural JK bank.
module tb_jk_bank_ctrl;
  import jk_bank_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          a_reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [N-1:0]  cmd_mask;
  logic [N-1:0]  cmd_data;
  logic [CW-1:0] cmd_count;
  logic [N-1:0]  ff_q = '0;
  logic [N-1:0]  ff_j;
  logic [N-1:0]  ff_k;
  logic          ff_enable;
  logic          ff_reset;
  logic          busy;
  logic          done;
  logic [N-1:0]  result;

  int n_checks = 0;
  int n_fail   = 0;
  logic [N-1:0] mv = '0;

  jk_bank_ctrl #(.N(N), .CW(CW)) dut (
    .clk       (clk),
    .a_reset   (a_reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_mask  (cmd_mask),
    .cmd_data  (cmd_data),
    .cmd_count (cmd_count),
    .ff_q      (ff_q),
    .ff_j      (ff_j),
    .ff_k      (ff_k),
    .ff_enable (ff_enable),
    .ff_reset  (ff_reset),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  always #5 clk = ~clk;

  // Behavioural bank of N JK flip-flops with shared enable and sync active-low reset.
  always @(posedge clk) begin
    if (!ff_reset) ff_q <= '0;
    else if (ff_enable) begin
      for (int i = 0; i < int'(N); i++) begin
        case ({ff_j[i], ff_k[i]})
          2'b10:   ff_q[i] <= 1'b1;
          2'b01:   ff_q[i] <= 1'b0;
          2'b11:   ff_q[i] <= ~ff_q[i];
          default: ff_q[i] <= ff_q[i];
        endcase
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference: value of the bank after a command, from the operation's meaning.
  function automatic logic [N-1:0] model_op(input logic [N-1:0] v, input logic [2:0] op,
                                            input logic [N-1:0] m, input logic [N-1:0] d,
                                            input logic [CW-1:0] c);
    case (op)
      OP_CLEAR:  return '0;
      OP_SET:    return v | m;
      OP_RESET:  return v & ~m;
      OP_TOGGLE: return v ^ m;
      OP_LOAD:   return (v & ~m) | (d & m);
      OP_CNT_UP: return v + c[N-1:0];
      OP_CNT_DN: return v - c[N-1:0];
      default:   return v;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [CW-1:0] c);
    return (op == OP_CNT_UP || op == OP_CNT_DN) ? int'(c) + 2 : 3;
  endfunction

  function automatic int model_edges(input logic [2:0] op, input logic [CW-1:0] c);
    if (op == OP_NOP) return 0;
    if (op == OP_CNT_UP || op == OP_CNT_DN) return int'(c);
    return 1;
  endfunction

  task automatic wait_ready();
    int w = 0;
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check_eq("ready_wait", 32'(cmd_ready), 32'd1);
  endtask

  // Issue one command at a negedge and follow it to its done pulse.
  task automatic run_cmd(input logic [2:0] op, input logic [N-1:0] m, input logic [N-1:0] d,
                         input logic [CW-1:0] c);
    int lat;
    int en_cnt;
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op = op; cmd_mask = m; cmd_data = d; cmd_count = c;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = 3'($urandom); cmd_mask = N'($urandom); cmd_data = N'($urandom);
    cmd_count = CW'($urandom);
    lat = 1;
    en_cnt = 0;
    while (!done && lat < 300) begin
      check_eq("busy_in_op", 32'(busy), 32'd1);
      en_cnt += int'(ff_enable);
      @(negedge clk);
      lat++;
    end
    mv = model_op(mv, op, m, d, c);
    check_eq("latency", 32'(lat), 32'(model_lat(op, c)));
    check_eq("enabled_cycles", 32'(en_cnt), 32'(model_edges(op, c)));
    check_eq("result", 32'(result), 32'(mv));
    check_eq("done_ready_low", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check_eq("done_one_cycle", 32'(done), 32'd0);
    check_eq("ready_after_done", 32'(cmd_ready), 32'd1);
    check_eq("result_hold", 32'(result), 32'(mv));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, 32'(cmd_ready), 32'd0);
    check_eq({tag, "_busy"},  32'(busy), 32'd0);
    check_eq({tag, "_done"},  32'(done), 32'd0);
    check_eq({tag, "_en"},    32'(ff_enable), 32'd0);
    check_eq({tag, "_rst"},   32'(ff_reset), 32'd1);
    check_eq({tag, "_j"},     32'(ff_j), 32'd0);
    check_eq({tag, "_k"},     32'(ff_k), 32'd0);
    check_eq({tag, "_res"},   32'(result), 32'd0);
  endtask

  initial begin
    int cyc;
    int exp_done;
    bit pending;
    logic acc;
    logic [2:0] op;
    logic [N-1:0] m;
    logic [N-1:0] d;
    logic [CW-1:0] c;
    int w;

    a_reset = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = OP_NOP; cmd_mask = '0; cmd_data = '0; cmd_count = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    a_reset = 1'b1;
    @(negedge clk);
    check_eq("ready_after_release", 32'(cmd_ready), 32'd1);
    check_eq("busy_after_release", 32'(busy), 32'd0);

    // Directed sequence.
    run_cmd(OP_CLEAR,  4'b0000, 4'b0000, 8'd0);
    check_eq("clear_val", 32'(result), 32'h0);
    run_cmd(OP_LOAD,   4'b1111, 4'b1010, 8'd0);
    check_eq("load_val", 32'(result), 32'hA);
    run_cmd(OP_TOGGLE, 4'b0011, 4'b0000, 8'd0);
    check_eq("toggle_val", 32'(result), 32'h9);
    run_cmd(OP_SET,    4'b0100, 4'b0000, 8'd0);
    check_eq("set_val", 32'(result), 32'hD);
    run_cmd(OP_RESET,  4'b1000, 4'b0000, 8'd0);
    check_eq("reset_val", 32'(result), 32'h5);
    run_cmd(OP_NOP,    4'b1111, 4'b1111, 8'd0);
    check_eq("nop_val", 32'(result), 32'h5);
    run_cmd(OP_LOAD,   4'b1111, 4'b1101, 8'd0);
    run_cmd(OP_CNT_UP, 4'b0000, 4'b0000, 8'd5);
    check_eq("cnt_up_wrap", 32'(result), 32'h2);
    run_cmd(OP_LOAD,   4'b1111, 4'b0001, 8'd0);
    run_cmd(OP_CNT_DN, 4'b0000, 4'b0000, 8'd3);
    check_eq("cnt_dn_wrap", 32'(result), 32'hE);
    run_cmd(OP_CNT_UP, 4'b0000, 4'b0000, 8'd0);
    check_eq("cnt_zero", 32'(result), 32'hE);

    // Randomized single commands.
    for (int i = 0; i < 25; i++) begin
      run_cmd(3'($urandom), N'($urandom), N'($urandom), CW'($urandom_range(0, 20)));
    end

    // cmd_valid held high with fields changing every cycle.
    cyc = 0; pending = 1'b0; exp_done = 0;
    for (int n = 0; n < 150; n++) begin
      check_eq("stress_done", 32'(done), 32'(pending && cyc == exp_done));
      if (pending && cyc == exp_done) begin
        check_eq("stress_result", 32'(result), 32'(mv));
        pending = 1'b0;
      end
      if (pending) check_eq("stress_ready_busy", 32'(cmd_ready), 32'd0);
      op = 3'($urandom); m = N'($urandom); d = N'($urandom);
      c = CW'($urandom_range(0, 6));
      cmd_valid = 1'b1;
      cmd_op = op; cmd_mask = m; cmd_data = d; cmd_count = c;
      acc = cmd_ready;
      if (acc) begin
        mv = model_op(mv, op, m, d, c);
        exp_done = cyc + model_lat(op, c);
        pending = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    cmd_valid = 1'b0;
    w = 0;
    while (pending && w < 20) begin
      check_eq("drain_done", 32'(done), 32'(cyc == exp_done));
      if (cyc == exp_done) begin
        check_eq("drain_result", 32'(result), 32'(mv));
        pending = 1'b0;
      end
      @(negedge clk);
      cyc++;
      w++;
    end
    check_eq("drain_complete", 32'(pending), 32'd0);

    // Reset in the middle of a count, with two edges still to go.
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op = OP_CNT_UP; cmd_mask = '0; cmd_data = '0; cmd_count = 8'd6;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("midcnt_busy", 32'(busy), 32'd1);
    check_eq("midcnt_en", 32'(ff_enable), 32'd1);
    mv = mv + 4'd4;
    check_eq("midcnt_bank", 32'(ff_q), 32'(mv));
    a_reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("midreset_no_done", 32'(done), 32'd0);
    end
    a_reset = 1'b1;
    @(negedge clk);
    check_eq("midreset_release_ready", 32'(cmd_ready), 32'd1);
    check_eq("midreset_bank_frozen", 32'(ff_q), 32'(mv));
    run_cmd(OP_CLEAR, 4'b0000, 4'b0000, 8'd0);
    check_eq("final_clear", 32'(result), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
